// File: rtl/lp_tree_deserializer.sv
// lp_tree_deserializer
//   Receive side of the 16:1 low-power tree serializer. Samples one serial bit
//   per CLK edge and finds frame boundaries by hunting for SYNC_WORD while
//   ALIGN_EN is high. Once locked, it presents each aligned frame on PAR_OUT
//   with a one-cycle PAR_VALID strobe, and it counts lock losses.
//
// Ports
//   CLK        bit clock (one serial bit per rising edge)
//   RESET      synchronous, active-high reset
//   SERIAL_IN  serial data; the first bit of a frame is bit 0
//   ALIGN_EN   high while the link carries SYNC_WORD training
//   PAR_OUT    last completed frame (registered, held between strobes)
//   PAR_VALID  one-cycle strobe; PAR_OUT was updated this cycle
//   LOCKED     high while in the LOCKED state
//   ERR_CNT    lock-loss counter, saturates at 255
module lp_tree_deserializer #(
   parameter int                    INPUTS_NUM  = 16,
   parameter logic [INPUTS_NUM-1:0] SYNC_WORD   = 16'hA5C3,
   parameter int                    LOCK_FRAMES = 2
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  SERIAL_IN,
   input  logic                  ALIGN_EN,
   output logic [INPUTS_NUM-1:0] PAR_OUT,
   output logic                  PAR_VALID,
   output logic                  LOCKED,
   output logic [7:0]            ERR_CNT
);

   localparam int BCW = $clog2(INPUTS_NUM);

   localparam logic [1:0] ST_HUNT   = 2'd0;
   localparam logic [1:0] ST_VERIFY = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   logic [1:0]            state;
   logic [INPUTS_NUM-1:0] sr;
   logic [INPUTS_NUM-1:0] word_next;
   logic [BCW-1:0]        bit_cnt;
   logic [3:0]            match_cnt;
   logic                  boundary;
   logic                  sync_hit;

   // LSB-first: the newest bit enters at the top, so after a full frame
   // bit 0 of that frame sits at word_next[0].
   assign word_next = {SERIAL_IN, sr[INPUTS_NUM-1:1]};
   assign boundary  = (bit_cnt == BCW'(INPUTS_NUM - 1));
   assign sync_hit  = (word_next == SYNC_WORD);
   assign LOCKED    = (state == ST_LOCKED);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ST_HUNT;
         sr        <= '0;
         bit_cnt   <= '0;
         match_cnt <= '0;
         PAR_OUT   <= '0;
         PAR_VALID <= 1'b0;
         ERR_CNT   <= '0;
      end else begin
         sr        <= word_next;
         bit_cnt   <= bit_cnt + BCW'(1);
         PAR_VALID <= 1'b0;
         case (state)
            ST_HUNT: begin
               // A match realigns the frame counter: the next sampled bit is
               // bit 0 of a fresh frame. ALIGN_EN low suppresses the match.
               if (ALIGN_EN && sync_hit) begin
                  bit_cnt   <= '0;
                  match_cnt <= 4'd1;
                  state     <= (LOCK_FRAMES == 1) ? ST_LOCKED : ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               if (!ALIGN_EN) begin
                  state     <= ST_HUNT;
                  match_cnt <= '0;
               end else if (boundary) begin
                  if (sync_hit) begin
                     match_cnt <= match_cnt + 4'd1;
                     if (match_cnt + 4'd1 == 4'(LOCK_FRAMES))
                        state <= ST_LOCKED;
                  end else begin
                     state     <= ST_HUNT;
                     match_cnt <= '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (boundary) begin
                  // Every frame is emitted, including sync words and the
                  // mismatching word that drops lock.
                  PAR_OUT   <= word_next;
                  PAR_VALID <= 1'b1;
                  if (ALIGN_EN && !sync_hit) begin
                     state     <= ST_HUNT;
                     match_cnt <= '0;
                     if (ERR_CNT != 8'hFF)
                        ERR_CNT <= ERR_CNT + 8'd1;
                  end
               end
            end
            default: begin
               state     <= ST_HUNT;
               match_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lp_tree_deserializer.sv
// Directed bench for lp_tree_deserializer: reset, acquisition, data while
// locked, lock loss and relock, VERIFY failure, ERR_CNT saturation and a
// mid-frame reset. Expected values are hand-derived constants.
module tb_lp_tree_deserializer;

   logic        CLK;
   logic        RESET;
   logic        SERIAL_IN;
   logic        ALIGN_EN;
   logic [15:0] PAR_OUT;
   logic        PAR_VALID;
   logic        LOCKED;
   logic [7:0]  ERR_CNT;

   int vectors;
   int miscompares;

   lp_tree_deserializer #(
      .INPUTS_NUM (16),
      .SYNC_WORD  (16'hA5C3),
      .LOCK_FRAMES(2)
   ) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .SERIAL_IN(SERIAL_IN),
      .ALIGN_EN (ALIGN_EN),
      .PAR_OUT  (PAR_OUT),
      .PAR_VALID(PAR_VALID),
      .LOCKED   (LOCKED),
      .ERR_CNT  (ERR_CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one bit, let the edge sample it, then settle 1 time unit past it.
   task automatic send_bit(input logic b);
      SERIAL_IN = b;
      @(posedge CLK);
      #1;
   endtask

   // Send a frame LSB-first. With chk_quiet set, PAR_VALID must stay low
   // after each of bits 0..14; the caller checks the state after bit 15.
   task automatic send_word(input logic [15:0] w, input bit chk_quiet);
      for (int i = 0; i < 16; i++) begin
         send_bit(w[i]);
         if (chk_quiet && i < 15) chk("quiet_mid_frame", {15'd0, PAR_VALID}, 16'd0);
      end
   endtask

   initial begin
      logic [15:0] part;
      vectors     = 0;
      miscompares = 0;
      RESET       = 1'b1;
      ALIGN_EN    = 1'b0;
      SERIAL_IN   = 1'b0;

      // Reset with random serial data
      for (int i = 0; i < 3; i++) begin
         send_bit(1'($urandom_range(0, 1)));
         chk("rst_par_out", PAR_OUT, 16'h0000);
         chk("rst_valid", {15'd0, PAR_VALID}, 16'd0);
         chk("rst_locked", {15'd0, LOCKED}, 16'd0);
         chk("rst_err", {8'd0, ERR_CNT}, 16'd0);
      end
      RESET = 1'b0;

      // Acquisition: 5 junk bits then three sync words
      ALIGN_EN = 1'b1;
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      send_word(16'hA5C3, 1'b1);
      chk("acq_w1_locked", {15'd0, LOCKED}, 16'd0);
      send_word(16'hA5C3, 1'b1);
      chk("acq_w2_locked", {15'd0, LOCKED}, 16'd1);
      chk("acq_w2_nostrobe", {15'd0, PAR_VALID}, 16'd0);
      send_word(16'hA5C3, 1'b1);
      chk("acq_w3_valid", {15'd0, PAR_VALID}, 16'd1);
      chk("acq_w3_data", PAR_OUT, 16'hA5C3);
      chk("acq_err", {8'd0, ERR_CNT}, 16'd0);

      // Data with alignment checking off
      ALIGN_EN = 1'b0;
      send_word(16'h1234, 1'b1);
      chk("dat1_valid", {15'd0, PAR_VALID}, 16'd1);
      chk("dat1_data", PAR_OUT, 16'h1234);
      send_word(16'hFFFF, 1'b1);
      chk("dat2_valid", {15'd0, PAR_VALID}, 16'd1);
      chk("dat2_data", PAR_OUT, 16'hFFFF);
      chk("dat_locked", {15'd0, LOCKED}, 16'd1);
      send_bit(1'b0);
      chk("dat_strobe_one_cycle", {15'd0, PAR_VALID}, 16'd0);
      chk("dat_hold", PAR_OUT, 16'hFFFF);
      for (int i = 1; i < 16; i++) send_bit(1'b0);
      chk("dat3_data", PAR_OUT, 16'h0000);

      // Lock loss on a corrupted sync word, then relock
      ALIGN_EN = 1'b1;
      send_word(16'hA5C2, 1'b1);
      chk("loss_valid", {15'd0, PAR_VALID}, 16'd1);
      chk("loss_data", PAR_OUT, 16'hA5C2);
      chk("loss_locked", {15'd0, LOCKED}, 16'd0);
      chk("loss_err", {8'd0, ERR_CNT}, 16'd1);
      send_word(16'h0000, 1'b1);
      send_word(16'hA5C3, 1'b1);
      chk("relock_w1", {15'd0, LOCKED}, 16'd0);
      send_word(16'hA5C3, 1'b1);
      chk("relock_w2", {15'd0, LOCKED}, 16'd1);
      send_word(16'hA5C3, 1'b1);
      chk("relock_strobe", {15'd0, PAR_VALID}, 16'd1);
      chk("relock_data", PAR_OUT, 16'hA5C3);

      // VERIFY failure: detection followed by a bad frame
      RESET = 1'b1;
      send_bit(1'b0);
      RESET = 1'b0;
      send_word(16'h0000, 1'b1);
      send_word(16'hA5C3, 1'b1);
      chk("vfy_w1_locked", {15'd0, LOCKED}, 16'd0);
      send_word(16'h0000, 1'b1);
      chk("vfy_fail_locked", {15'd0, LOCKED}, 16'd0);
      chk("vfy_fail_valid", {15'd0, PAR_VALID}, 16'd0);
      chk("vfy_fail_err", {8'd0, ERR_CNT}, 16'd0);
      // Back in HUNT, a single sync is only a fresh detection.
      send_word(16'hA5C3, 1'b1);
      chk("vfy_rehunt_locked", {15'd0, LOCKED}, 16'd0);

      // Saturation: 256 lock losses
      RESET = 1'b1;
      send_bit(1'b0);
      RESET = 1'b0;
      for (int n = 1; n <= 256; n++) begin
         send_word(16'h0000, 1'b0);
         send_word(16'hA5C3, 1'b0);
         send_word(16'hA5C3, 1'b0);
         if (n == 1) chk("sat_locked", {15'd0, LOCKED}, 16'd1);
         send_word(16'hA5C2, 1'b0);
         if (n == 2)   chk("sat_err_2", {8'd0, ERR_CNT}, 16'd2);
         if (n == 254) chk("sat_err_254", {8'd0, ERR_CNT}, 16'd254);
         if (n == 255) chk("sat_err_255", {8'd0, ERR_CNT}, 16'd255);
      end
      chk("sat_err_256", {8'd0, ERR_CNT}, 16'd255);
      chk("sat_unlocked", {15'd0, LOCKED}, 16'd0);

      // Mid-frame reset at bit 7 of a locked frame
      send_word(16'h0000, 1'b0);
      send_word(16'hA5C3, 1'b0);
      send_word(16'hA5C3, 1'b0);
      chk("mid_locked", {15'd0, LOCKED}, 16'd1);
      part = 16'h5A5A;
      for (int i = 0; i < 7; i++) send_bit(part[i]);
      RESET = 1'b1;
      send_bit(part[7]);
      chk("mid_rst_err", {8'd0, ERR_CNT}, 16'd0);
      chk("mid_rst_locked", {15'd0, LOCKED}, 16'd0);
      chk("mid_rst_par_out", PAR_OUT, 16'h0000);
      chk("mid_rst_valid", {15'd0, PAR_VALID}, 16'd0);
      RESET = 1'b0;
      for (int i = 8; i < 16; i++) begin
         send_bit(part[i]);
         chk("mid_partial_nostrobe", {15'd0, PAR_VALID}, 16'd0);
      end
      send_bit(1'b0);
      chk("mid_after_nostrobe", {15'd0, PAR_VALID}, 16'd0);
      chk("mid_after_err", {8'd0, ERR_CNT}, 16'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Safety net against a stalled run.
   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lp_tree_deserializer.md
# lp_tree_deserializer

Receive-side counterpart of the 16:1 low-power tree serializer: samples the full-rate serial line on `CLK`, locates frame boundaries by hunting for a training word, and presents each aligned 16-bit frame as a parallel word with a one-cycle valid strobe. It sits at the receive end of the serial link, feeding core logic with words in the same bit order the serializer consumed them. It reports lock status and counts lock losses for link bring-up and debug.

## Interface
- `INPUTS_NUM`, 16: frame width in bits. It matches the serializer's `INPUTS_NUM`. Only 16 is required to be supported.
- `SYNC_WORD`, 16'hA5C3: training word sent by the transmitter while alignment is enabled.
- `LOCK_FRAMES`, 2: consecutive sync matches needed to declare lock. The count includes the initial detection. Legal range is 1..15.
- `CLK`  input  1: bit clock, one serial bit per rising edge. This is the only clock.
- `RESET`  input  1: synchronous, active-high reset.
- `SERIAL_IN`  input  1: serial data, first bit of a frame = bit 0.
- `ALIGN_EN`  input  1: high while the link carries repeated `SYNC_WORD` training.
- `PAR_OUT`  output  INPUTS_NUM: last completed frame, registered.
- `PAR_VALID`  output  1: one-cycle strobe, `PAR_OUT` updated this cycle.
- `LOCKED`  output  1: high in LOCKED state.
- `ERR_CNT`  output  8: lock-loss counter, saturating at 255.

## Operation
- Shift register `sr` (16 bits), LSB-first. Each cycle, `word_next = {SERIAL_IN, sr[15:1]}` and `sr <= word_next`.
- Bit counter `bit_cnt` (4 bits) increments mod 16 every cycle. A "boundary" is a cycle with `bit_cnt == 15`.
- States:
  - HUNT (reset state). If ALIGN_EN=1, compare `word_next` to `SYNC_WORD` every cycle. On a match: `bit_cnt <= 0` and `match_cnt <= 1`. Go to LOCKED if `LOCK_FRAMES == 1`, otherwise go to VERIFY. If ALIGN_EN=0, stay in HUNT.
  - VERIFY. At each boundary:
    - If `word_next == SYNC_WORD` and ALIGN_EN=1, `match_cnt++`. When `match_cnt` reaches `LOCK_FRAMES`, go to LOCKED.
    - On any mismatch, go to HUNT. Do not increment ERR_CNT.
    - If ALIGN_EN=0 in any cycle, go to HUNT immediately.
  - LOCKED. At each boundary: `PAR_OUT <= word_next` and `PAR_VALID <= 1`; sync words are also emitted. If ALIGN_EN=1 and `word_next != SYNC_WORD`:
    - go to HUNT;
    - increment ERR_CNT, saturating at 255;
    - the mismatching word is still emitted with PAR_VALID.

    With ALIGN_EN=0, no checking is done and lock is held indefinitely.
- `PAR_VALID` is never asserted in HUNT or VERIFY. `PAR_OUT` holds its last value between strobes.
- `bit_cnt` is not realigned in VERIFY or LOCKED. Realignment happens only in HUNT.

## Timing
- Reset values: `sr`=0, `bit_cnt`=0, state HUNT, `match_cnt`=0. Outputs: `PAR_OUT`=0, `PAR_VALID`=0, `LOCKED`=0, `ERR_CNT`=0.
- RESET asserted mid-frame clears everything at that edge. The partial frame is discarded with no PAR_VALID. Hunting resumes on the first edge with RESET low.
- Latency: the edge that samples the last bit of a frame also registers `PAR_OUT` and `PAR_VALID`. Both are visible in the following cycle, so latency is 1 cycle after the last bit. Strobes occur every 16 cycles while locked.
- `LOCKED` rises in the cycle after the edge that samples the last bit of the `LOCK_FRAMES`-th consecutive sync word. That word itself gets no strobe; the first strobe is for the next frame.
- `LOCKED` falls in the cycle after the mismatching boundary, in the same cycle as that word's PAR_VALID and the ERR_CNT increment.
- Simultaneous HUNT match and ALIGN_EN fall: ALIGN_EN=0 wins, and the block stays in HUNT.
- ERR_CNT at 255 plus another lock loss: it stays at 255. Only RESET clears it.

## Test plan
- Reset: drive RESET for 3 cycles with random SERIAL_IN. Required: all outputs 0, LOCKED=0, no PAR_VALID.
- Acquisition: ALIGN_EN=1. Send 5 junk bits, then 16'hA5C3 three times, LSB-first. Required: LOCKED=1 exactly one cycle after the last bit of the 2nd sync word. One PAR_VALID with PAR_OUT=16'hA5C3 arrives one cycle after the 3rd word. ERR_CNT=0.
- Data: from lock, drop ALIGN_EN, then send 16'h1234 and then 16'hFFFF. Required: PAR_OUT=16'h1234 with PAR_VALID one cycle after its bit 15, and 16'hFFFF strobed exactly 16 cycles later. LOCKED stays 1.
- Lock loss: locked with ALIGN_EN=1, send 16'hA5C2. Required: PAR_VALID with PAR_OUT=16'hA5C2, LOCKED=0 and ERR_CNT=1 in the same cycle. Subsequent sync words relock after 2 words.
- VERIFY failure: detection of 16'hA5C3 followed by 16'h0000. Required: back to HUNT, LOCKED never set, no PAR_VALID, ERR_CNT=0.
- Saturation and mid-frame reset: force 256 lock losses. Required: ERR_CNT=255. Then assert RESET at bit 7 of a frame. Required: ERR_CNT=0, no strobe for the partial frame.
